// File: rtl/nand_dq_burst_responder.sv
// Target-side NAND DQ/DQS read-burst generator: preamble, table or counter data, postamble.
// All outputs are registered and derived from the next FSM state.
module nand_dq_burst_responder #(
    parameter int DQ_W      = 8,
    parameter int NUM_CE    = 2,
    parameter int PAT_DEPTH = 4,
    parameter int PAT_AW    = $clog2(PAT_DEPTH),
    parameter int CE_W      = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cfg_wr_en,
    input  logic [PAT_AW-1:0] cfg_wr_addr,
    input  logic [DQ_W-1:0]   cfg_wr_data,
    input  logic              cfg_mode,
    input  logic [15:0]       cfg_burst_len,
    input  logic [3:0]        cfg_preamble,
    input  logic              ale,
    input  logic              cle,
    input  logic              wrn,
    input  logic [NUM_CE-1:0] cen,
    output logic [DQ_W-1:0]   dq_out,
    output logic              dq_oe,
    output logic              dqs_out,
    output logic              dqs_oe,
    output logic              busy,
    output logic [CE_W-1:0]   active_ce,
    output logic              burst_done,
    output logic              burst_abort
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_POST
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [3:0]        r_pre_cnt;
    logic [3:0]        w_pre_cnt_nxt;
    logic [15:0]       r_k;
    logic [15:0]       r_len;
    logic [15:0]       w_nk;
    logic              r_mode;
    logic              w_mode;
    logic [CE_W-1:0]   r_ce;
    logic [CE_W-1:0]   w_ce_sel;
    logic              w_trig;
    logic              w_abort_cond;
    logic              w_abort;
    logic [DQ_W-1:0]   w_word;
    logic [DQ_W-1:0]   r_pat [PAT_DEPTH];

    logic [DQ_W-1:0]   r_dq;
    logic              r_dq_oe;
    logic              r_dqs;
    logic              r_dqs_oe;
    logic              r_busy;
    logic              r_done;
    logic              r_abort;

    assign w_trig       = !ale && !cle && !wrn && (cen != '1);
    assign w_abort_cond = ale || cle || wrn || cen[r_ce];

    always_comb begin
        logic found;
        found    = 1'b0;
        w_ce_sel = '0;
        for (int unsigned i = 0; i < NUM_CE; i++) begin
            if (!cen[i] && !found) begin
                w_ce_sel = CE_W'(i);
                found    = 1'b1;
            end
        end
    end

    // w_nk is the word index that will be on the bus in the next state.
    always_comb begin
        w_nxt         = r_state;
        w_pre_cnt_nxt = r_pre_cnt;
        w_nk          = '0;
        w_abort       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    if (cfg_preamble != '0) begin
                        w_nxt         = S_PRE;
                        w_pre_cnt_nxt = cfg_preamble - 4'd1;
                    end else if (cfg_burst_len != '0) begin
                        w_nxt = S_DATA;
                    end else begin
                        w_nxt = S_POST;
                    end
                end
            end
            S_PRE: begin
                if (w_abort_cond) begin
                    w_nxt   = S_IDLE;
                    w_abort = 1'b1;
                end else if (r_pre_cnt == '0) begin
                    w_nxt = (r_len != '0) ? S_DATA : S_POST;
                end else begin
                    w_pre_cnt_nxt = r_pre_cnt - 4'd1;
                end
            end
            S_DATA: begin
                w_nk = r_k + 16'd1;
                if (w_abort_cond) begin
                    w_nxt   = S_IDLE;
                    w_abort = 1'b1;
                end else if (w_nk == r_len) begin
                    w_nxt = S_POST;
                end
            end
            S_POST:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Straight from IDLE the mode has not been latched yet, so use the live input.
    assign w_mode = (r_state == S_IDLE) ? cfg_mode : r_mode;
    assign w_word = w_mode ? (r_pat[0] + w_nk[DQ_W-1:0]) : r_pat[w_nk[PAT_AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_pre_cnt <= '0;
            r_k       <= '0;
            r_len     <= '0;
            r_mode    <= 1'b0;
            r_ce      <= '0;
            r_pat     <= '{default: '0};
            r_dq      <= '0;
            r_dq_oe   <= 1'b0;
            r_dqs     <= 1'b0;
            r_dqs_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            if (cfg_wr_en) begin
                r_pat[cfg_wr_addr] <= cfg_wr_data;
            end
            r_state   <= w_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            if (r_state == S_IDLE && w_trig) begin
                r_ce   <= w_ce_sel;
                r_mode <= cfg_mode;
                r_len  <= cfg_burst_len;
            end
            if (w_nxt == S_DATA) begin
                r_k <= w_nk;
            end
            r_dq_oe  <= (w_nxt == S_DATA);
            r_dq     <= (w_nxt == S_DATA) ? w_word : '0;
            r_dqs_oe <= (w_nxt != S_IDLE);
            r_dqs    <= (w_nxt == S_DATA) && !w_nk[0];
            r_busy   <= (w_nxt != S_IDLE);
            r_done   <= (w_nxt == S_POST);
            r_abort  <= w_abort;
        end
    end

    assign dq_out      = r_dq;
    assign dq_oe       = r_dq_oe;
    assign dqs_out     = r_dqs;
    assign dqs_oe      = r_dqs_oe;
    assign busy        = r_busy;
    assign active_ce   = r_ce;
    assign burst_done  = r_done;
    assign burst_abort = r_abort;

endmodule

// File: tb/tb_nand_dq_burst_responder.sv
// Scoreboard bench for nand_dq_burst_responder: bursts are planned from the rules,
// expected per-cycle bus records queued, and a negedge monitor compares.
module tb_nand_dq_burst_responder;

    localparam int DQ_W      = 8;
    localparam int NUM_CE    = 2;
    localparam int PAT_DEPTH = 4;
    localparam int PAT_AW    = 2;
    localparam int CE_W      = 1;

    logic              CLK;
    logic              RST_N;
    logic              cfg_wr_en;
    logic [PAT_AW-1:0] cfg_wr_addr;
    logic [DQ_W-1:0]   cfg_wr_data;
    logic              cfg_mode;
    logic [15:0]       cfg_burst_len;
    logic [3:0]        cfg_preamble;
    logic              ale, cle, wrn;
    logic [NUM_CE-1:0] cen;
    logic [DQ_W-1:0]   dq_out;
    logic              dq_oe, dqs_out, dqs_oe, busy;
    logic [CE_W-1:0]   active_ce;
    logic              burst_done, burst_abort;

    nand_dq_burst_responder #(
        .DQ_W     (DQ_W),
        .NUM_CE   (NUM_CE),
        .PAT_DEPTH(PAT_DEPTH)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_mode     (cfg_mode),
        .cfg_burst_len(cfg_burst_len),
        .cfg_preamble (cfg_preamble),
        .ale          (ale),
        .cle          (cle),
        .wrn          (wrn),
        .cen          (cen),
        .dq_out       (dq_out),
        .dq_oe        (dq_oe),
        .dqs_out      (dqs_out),
        .dqs_oe       (dqs_oe),
        .busy         (busy),
        .active_ce    (active_ce),
        .burst_done   (burst_done),
        .burst_abort  (burst_abort)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       dq_oe;
        logic [7:0] dq;
        logic       dqs_oe;
        logic       dqs;
        logic       busy;
        logic       ce;
        logic       done;
        logic       abort;
    } rec_t;

    rec_t       exp_q[$];
    rec_t       mon_e, mon_o;
    int         checks = 0;
    int         errors = 0;
    bit         sb_en  = 1'b0;
    logic [7:0] tbl     [PAT_DEPTH];
    logic [7:0] tbl_new [PAT_DEPTH];

    function automatic rec_t mk(input logic doe, input logic [7:0] d, input logic soe,
                                input logic s, input logic b, input logic c,
                                input logic dn, input logic ab);
        rec_t r;
        r.dq_oe = doe; r.dq = d; r.dqs_oe = soe; r.dqs = s;
        r.busy = b; r.ce = c; r.done = dn; r.abort = ab;
        return r;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("dq_oe=%0b dq=%02h dqs_oe=%0b dqs=%0b busy=%0b ce=%0d done=%0b abort=%0b",
                         r.dq_oe, r.dq, r.dqs_oe, r.dqs, r.busy, r.ce, r.done, r.abort);
    endfunction

    // Word k of a burst: table entry k mod depth, or entry 0 plus k modulo 256.
    function automatic logic [7:0] model_word(input bit mode, input int k, input bit use_new);
        int p0, pk;
        p0 = use_new ? int'(tbl_new[0]) : int'(tbl[0]);
        pk = use_new ? int'(tbl_new[k % PAT_DEPTH]) : int'(tbl[k % PAT_DEPTH]);
        return mode ? 8'((p0 + k) % 256) : 8'(pk);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (sb_en && RST_N) begin
            checks++;
            mon_o = mk(dq_oe, dq_out, dqs_oe, dqs_out, busy, active_ce[0], burst_done, burst_abort);
            if (dq_oe || dqs_oe || burst_done || burst_abort) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got %s expected idle", fmt(mon_o));
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_o !== mon_e) begin
                        errors++;
                        $display("FAIL burst_cycle got %s expected %s", fmt(mon_o), fmt(mon_e));
                    end
                end
            end else if (busy !== 1'b0 || dq_out !== 8'h00 || dqs_out !== 1'b0) begin
                errors++;
                $display("FAIL idle_bus got %s expected busy=0 dq=00 dqs=0", fmt(mon_o));
            end
        end
    end

    task automatic bus_idle();
        ale = 1'b0; cle = 1'b0; wrn = 1'b1; cen = '1;
    endtask

    task automatic write_tbl(input int a, input logic [7:0] d);
        cfg_wr_en = 1'b1; cfg_wr_addr = PAT_AW'(a); cfg_wr_data = d;
        @(posedge CLK); #1;
        cfg_wr_en = 1'b0;
        tbl[a] = d;
    endtask

    // abort_at / wr_at are cycle indices after the trigger edge (-1 = none).
    task automatic burst(input int pre, input int len, input bit mode, input logic [1:0] cv,
                         input int abort_at, input int abort_kind, input int wr_at,
                         input int wr_addr, input logic [7:0] wr_data, input bit glitch);
        int  n, last, k;
        logic ce;
        ce = cv[0] ? 1'b1 : 1'b0;
        for (int i = 0; i < PAT_DEPTH; i++) tbl_new[i] = tbl[i];
        if (wr_at >= 0) tbl_new[wr_addr] = wr_data;
        n = pre + len;
        for (int c = 0; c < n; c++) begin
            if (abort_at >= 0 && c > abort_at) break;
            if (c < pre) begin
                exp_q.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, ce, 1'b0, 1'b0));
            end else begin
                k = c - pre;
                exp_q.push_back(mk(1'b1, model_word(mode, k, wr_at >= 0 && c >= wr_at + 2),
                                   1'b1, (k % 2) == 0, 1'b1, ce, 1'b0, 1'b0));
            end
        end
        if (abort_at >= 0) exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ce, 1'b0, 1'b1));
        else               exp_q.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, ce, 1'b1, 1'b0));
        last = (abort_at >= 0) ? abort_at + 1 : n;

        cfg_mode = mode; cfg_burst_len = 16'(len); cfg_preamble = 4'(pre);
        ale = 1'b0; cle = 1'b0; wrn = 1'b0; cen = cv;
        @(posedge CLK); #1;
        cfg_mode = 1'($urandom); cfg_burst_len = 16'($urandom); cfg_preamble = 4'($urandom);
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin @(posedge CLK); #1; end
            cfg_wr_en = (c == wr_at);
            if (c == wr_at) begin cfg_wr_addr = PAT_AW'(wr_addr); cfg_wr_data = wr_data; end
            if (glitch && c == 0) cen = '0;
            if (c == abort_at) begin
                case (abort_kind)
                    0:       wrn = 1'b1;
                    1:       ale = 1'b1;
                    2:       cle = 1'b1;
                    default: cen[ce] = 1'b1;
                endcase
            end
            if (c == last) bus_idle();
        end
        @(posedge CLK); #1;
        cfg_wr_en = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        for (int i = 0; i < PAT_DEPTH; i++) tbl[i] = tbl_new[i];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre, len, n, ab, kind, last, wr;
        logic [1:0] cv;
        RST_N = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_mode = 1'b0; cfg_burst_len = '0; cfg_preamble = '0;
        bus_idle();
        for (int i = 0; i < PAT_DEPTH; i++) tbl[i] = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dq_out", 32'(dq_out), 32'h0);
        chk("rst_dq_oe", 32'(dq_oe), 32'h0);
        chk("rst_dqs_out", 32'(dqs_out), 32'h0);
        chk("rst_dqs_oe", 32'(dqs_oe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_active_ce", 32'(active_ce), 32'h0);
        chk("rst_done", 32'(burst_done), 32'h0);
        chk("rst_abort", 32'(burst_abort), 32'h0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        sb_en = 1'b1;

        write_tbl(0, 8'hDE); write_tbl(1, 8'hAD); write_tbl(2, 8'hBE); write_tbl(3, 8'hEF);
        burst(0, 4, 1'b0, 2'b10, -1, 0, -1, 0, 8'h00, 1'b0);
        burst(2, 6, 1'b0, 2'b10, -1, 0, -1, 0, 8'h00, 1'b0);
        burst(0, 0, 1'b0, 2'b10, -1, 0, -1, 0, 8'h00, 1'b0);
        burst(0, 8, 1'b0, 2'b10, 3, 0, -1, 0, 8'h00, 1'b0);
        burst(1, 5, 1'b0, 2'b01, -1, 0, -1, 0, 8'h00, 1'b1);
        burst(3, 4, 1'b0, 2'b01, 1, 3, -1, 0, 8'h00, 1'b0);
        burst(0, 6, 1'b0, 2'b10, -1, 0, 1, 3, 8'h55, 1'b0);
        write_tbl(0, 8'hFE);
        burst(0, 4, 1'b1, 2'b10, -1, 0, -1, 0, 8'h00, 1'b0);

        for (int t = 0; t < 40; t++) begin
            pre  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
            len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(11, 24)) : int'($urandom_range(0, 10));
            n    = pre + len;
            ab   = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            kind = int'($urandom_range(0, 3));
            last = (ab >= 0) ? ab + 1 : n;
            wr   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, last)) : -1;
            case ($urandom_range(0, 2))
                0:       cv = 2'b00;
                1:       cv = 2'b01;
                default: cv = 2'b10;
            endcase
            if ($urandom_range(0, 3) == 0) write_tbl(int'($urandom_range(0, 3)), 8'($urandom));
            burst(pre, len, 1'($urandom), cv, ab, kind, wr,
                  int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
        end

        // Asynchronous reset in the middle of a data phase.
        sb_en = 1'b0;
        cfg_mode = 1'b0; cfg_burst_len = 16'd8; cfg_preamble = 4'd0;
        ale = 1'b0; cle = 1'b0; wrn = 1'b0; cen = 2'b10;
        repeat (3) begin @(posedge CLK); #1; end
        chk("pre_reset_dq_oe", 32'(dq_oe), 32'h1);
        chk("pre_reset_dq", 32'(dq_out), 32'(tbl[2]));
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_dq_oe", 32'(dq_oe), 32'h0);
        chk("async_rst_dqs_oe", 32'(dqs_oe), 32'h0);
        chk("async_rst_dq_out", 32'(dq_out), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        bus_idle();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int i = 0; i < PAT_DEPTH; i++) tbl[i] = 8'h00;
        @(posedge CLK); #1;
        sb_en = 1'b1;
        burst(0, 4, 1'b0, 2'b10, -1, 0, -1, 0, 8'h00, 1'b0);
        burst(1, 3, 1'b1, 2'b01, -1, 0, -1, 0, 8'h00, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
